// File: rtl/gpio_set_sequencer_if.sv
// Command and status bundle between a controller and gpio_set_sequencer.
// The controller owns the master side; the sequencer owns the slave side.
interface gpio_set_sequencer_if #(
    parameter int SET_WIDTH   = 4,
    parameter int DWELL_WIDTH = 32,
    parameter int PASS_WIDTH  = 16
);
    logic                   START;
    logic                   STOP;
    logic [SET_WIDTH-1:0]   FIRST_SET;
    logic [SET_WIDTH-1:0]   LAST_SET;
    logic [DWELL_WIDTH-1:0] DWELL;
    logic                   LOOP;
    logic [SET_WIDTH-1:0]   SET;
    logic                   SET_STROBE;
    logic                   BUSY;
    logic                   DONE;
    logic [PASS_WIDTH-1:0]  PASS_COUNT;

    modport master (
        output START, STOP, FIRST_SET, LAST_SET, DWELL, LOOP,
        input  SET, SET_STROBE, BUSY, DONE, PASS_COUNT
    );

    modport slave (
        input  START, STOP, FIRST_SET, LAST_SET, DWELL, LOOP,
        output SET, SET_STROBE, BUSY, DONE, PASS_COUNT
    );
endinterface

// File: rtl/gpio_set_sequencer.sv
// Steps the GPIO parameter-set select through a contiguous, possibly wrapping
// range, holding each set for a programmable dwell, once or continuously.
module gpio_set_sequencer #(
    parameter int SET_WIDTH   = 4,
    parameter int DWELL_WIDTH = 32,
    parameter int PASS_WIDTH  = 16
) (
    input logic                 CLK,
    input logic                 RESETN,
    gpio_set_sequencer_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [SET_WIDTH-1:0]   set_q;
    logic                   strobe_q;
    logic                   busy_q;
    logic                   done_q;
    logic [PASS_WIDTH-1:0]  pass_q;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [SET_WIDTH-1:0]   first_q;
    logic [SET_WIDTH-1:0]   last_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic                   loop_q;

    // dwell_cnt counts 1..D for the cycles the current set has been visible,
    // so the full DWELL_WIDTH range is usable without overflow.
    logic                   expired;
    logic [PASS_WIDTH-1:0]  pass_next;

    assign expired   = (dwell_cnt == dwell_q);
    assign pass_next = (pass_q == '1) ? pass_q : pass_q + 1'b1;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state     <= IDLE;
            set_q     <= '0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= '0;
            dwell_cnt <= '0;
            // NOTE: the latched range/dwell registers are reset too; they are
            // reloaded on every START, so this only gives a clean power-up view.
            first_q   <= '0;
            last_q    <= '0;
            dwell_q   <= '0;
            loop_q    <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            done_q   <= 1'b0;

            if (state == IDLE) begin
                if (bus.START && !bus.STOP) begin
                    first_q   <= bus.FIRST_SET;
                    last_q    <= bus.LAST_SET;
                    dwell_q   <= (bus.DWELL == '0) ? DWELL_WIDTH'(1) : bus.DWELL;
                    loop_q    <= bus.LOOP;
                    set_q     <= bus.FIRST_SET;
                    strobe_q  <= 1'b1;
                    busy_q    <= 1'b1;
                    pass_q    <= '0;
                    dwell_cnt <= DWELL_WIDTH'(1);
                    state     <= RUN;
                end
            end else begin
                if (bus.STOP) begin
                    // Abort freezes SET and the pass count; no DONE.
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end else if (!expired) begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                end else if (set_q != last_q) begin
                    set_q     <= set_q + 1'b1;
                    strobe_q  <= 1'b1;
                    dwell_cnt <= DWELL_WIDTH'(1);
                end else if (loop_q) begin
                    set_q     <= first_q;
                    strobe_q  <= 1'b1;
                    pass_q    <= pass_next;
                    dwell_cnt <= DWELL_WIDTH'(1);
                end else begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= pass_next;
                    state  <= IDLE;
                end
            end
        end
    end

    assign bus.SET        = set_q;
    assign bus.SET_STROBE = strobe_q;
    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.PASS_COUNT = pass_q;

endmodule

// File: tb/tb_gpio_set_sequencer.sv
// Directed bench for gpio_set_sequencer: each scenario task drives stimulus
// and compares the {SET, SET_STROBE, BUSY, DONE, PASS_COUNT} snapshot inline.
module tb_gpio_set_sequencer;
    localparam int SW = 4;
    localparam int DW = 32;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    gpio_set_sequencer_if #(.SET_WIDTH(SW), .DWELL_WIDTH(DW), .PASS_WIDTH(PW)) bus ();

    gpio_set_sequencer #(.SET_WIDTH(SW), .DWELL_WIDTH(DW), .PASS_WIDTH(PW)) dut (
        .CLK    (clk),
        .RESETN (rst_n),
        .bus    (bus)
    );

    typedef logic [SW+3+PW-1:0] snap_t;

    function automatic snap_t snap();
        return {bus.SET, bus.SET_STROBE, bus.BUSY, bus.DONE, bus.PASS_COUNT};
    endfunction

    function automatic snap_t mk(input int set, input bit stb, input bit busy,
                                 input bit done, input int pass);
        return {SW'(set), stb, busy, done, PW'(pass)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit start, input bit stop, input int first, input int last,
                         input int dwell, input bit loop);
        bus.START     = start;
        bus.STOP      = stop;
        bus.FIRST_SET = SW'(first);
        bus.LAST_SET  = SW'(last);
        bus.DWELL     = DW'(dwell);
        bus.LOOP      = loop;
    endtask

    task automatic test_reset();
        snap_t exp;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        exp = mk(0, 0, 0, 0, 0);
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL reset: got %h want %h", snap(), exp);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", snap(), exp);
        end
    endtask

    // 2..5, dwell 3, single pass; then a START in the DONE cycle for a wrapping run.
    task automatic test_back_to_back();
        int    es[12] = '{2, 2, 2, 3, 3, 3, 4, 4, 4, 5, 5, 5};
        bit    eb[12] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
        int    ws[4]  = '{14, 15, 0, 1};
        snap_t exp;
        drive(1, 0, 2, 5, 3, 0);
        tick();
        drive(0, 0, 2, 5, 3, 0);
        for (int k = 0; k < 12; k++) begin
            exp = mk(es[k], eb[k], 1, 0, 0);
            checks++;
            if (snap() !== exp) begin
                errors++;
                $display("FAIL basic_cyc%0d: got %h want %h", k + 1, snap(), exp);
            end
            tick();
        end
        exp = mk(5, 0, 0, 1, 1);
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL basic_done: got %h want %h", snap(), exp);
        end
        drive(1, 0, 14, 1, 0, 0);
        tick();
        drive(0, 0, 14, 1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            exp = mk(ws[k], 1, 1, 0, 0);
            checks++;
            if (snap() !== exp) begin
                errors++;
                $display("FAIL wrap_cyc%0d: got %h want %h", k + 1, snap(), exp);
            end
            tick();
        end
        exp = mk(1, 0, 0, 1, 1);
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL wrap_done: got %h want %h", snap(), exp);
        end
        tick();
        exp = mk(1, 0, 0, 0, 1);
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL wrap_done_clear: got %h want %h", snap(), exp);
        end
    endtask

    // 0..1, dwell 2, loop; ten passes then STOP.
    task automatic test_loop_stop();
        int    es[4] = '{0, 0, 1, 1};
        bit    eb[4] = '{1, 0, 1, 0};
        snap_t exp;
        drive(1, 0, 0, 1, 2, 1);
        tick();
        drive(0, 0, 0, 1, 2, 1);
        for (int k = 0; k < 40; k++) begin
            exp = mk(es[k % 4], eb[k % 4], 1, 0, k / 4);
            checks++;
            if (snap() !== exp) begin
                errors++;
                $display("FAIL loop_cyc%0d: got %h want %h", k + 1, snap(), exp);
            end
            tick();
        end
        exp = mk(0, 1, 1, 0, 10);
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL loop_pass10: got %h want %h", snap(), exp);
        end
        drive(0, 1, 0, 1, 2, 1);
        tick();
        drive(0, 0, 0, 1, 2, 1);
        for (int k = 0; k < 4; k++) begin
            exp = mk(0, 0, 0, 0, 10);
            checks++;
            if (snap() !== exp) begin
                errors++;
                $display("FAIL loop_stopped%0d: got %h want %h", k, snap(), exp);
            end
            tick();
        end
    endtask

    task automatic test_start_stop_idle();
        snap_t exp;
        drive(1, 1, 6, 7, 1, 0);
        tick();
        drive(0, 0, 6, 7, 1, 0);
        exp = mk(0, 0, 0, 0, 10);
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL start_stop_idle: got %h want %h", snap(), exp);
        end
        tick();
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL start_stop_idle_after: got %h want %h", snap(), exp);
        end
    endtask

    // A second START with different operands mid-run must be ignored.
    task automatic test_start_ignored();
        snap_t exps[6];
        exps = '{mk(3, 1, 1, 0, 0), mk(3, 0, 1, 0, 0), mk(4, 1, 1, 0, 0),
                 mk(4, 0, 1, 0, 0), mk(4, 0, 0, 1, 1), mk(4, 0, 0, 0, 1)};
        drive(1, 0, 3, 4, 2, 0);
        tick();
        drive(1, 0, 8, 12, 5, 1);
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (snap() !== exps[k]) begin
                errors++;
                $display("FAIL start_ignored_cyc%0d: got %h want %h", k + 1, snap(), exps[k]);
            end
            tick();
            drive(0, 0, 8, 12, 5, 1);
        end
    endtask

    task automatic test_reset_mid_run();
        snap_t exp;
        drive(1, 0, 5, 10, 1, 1);
        tick();
        drive(0, 0, 5, 10, 1, 1);
        for (int k = 0; k < 3; k++) begin
            exp = mk(5 + k, 1, 1, 0, 0);
            checks++;
            if (snap() !== exp) begin
                errors++;
                $display("FAIL pre_reset_cyc%0d: got %h want %h", k + 1, snap(), exp);
            end
            if (k < 2) tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp = mk(0, 0, 0, 0, 0);
        checks++;
        if (snap() !== exp) begin
            errors++;
            $display("FAIL reset_mid_run: got %h want %h", snap(), exp);
        end
    endtask

    task automatic test_single_set();
        snap_t exps[3];
        exps = '{mk(9, 1, 1, 0, 0), mk(9, 0, 0, 1, 1), mk(9, 0, 0, 0, 1)};
        drive(1, 0, 9, 9, 1, 0);
        tick();
        drive(0, 0, 9, 9, 1, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (snap() !== exps[k]) begin
                errors++;
                $display("FAIL single_set_cyc%0d: got %h want %h", k + 1, snap(), exps[k]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_loop_stop();
        test_start_stop_idle();
        test_start_ignored();
        test_reset_mid_run();
        test_single_set();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
